uart_imem_loader: RTL

UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

---
 rtl/uart_imem_loader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_imem_loader.sv
// UART boot loader: receives 0x55, a word count N, then N little-endian
// 32-bit words over 8N1 serial and writes them into instruction memory.
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MEM_WORDS    = 14
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RX,
    output logic        WE,
    output logic [31:0] A,
    output logic [31:0] WD,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]    N_MAX     = 8'(MEM_WORDS);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
    typedef enum logic [1:0] {L_IDLE, L_COUNT, L_DATA, L_WRITE} ld_st_t;

    rx_st_t        rst;
    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_byte;
    logic          rx_vld, rx_ferr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
            rst     <= R_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            rx_byte <= '0;
            rx_vld  <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_vld  <= 1'b0;
            rx_ferr <= 1'b0;
            case (rst)
                R_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rst <= R_START;
                        cnt <= '0;
                    end
                end
                R_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        rst     <= rx_s2 ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        rx_byte <= {rx_s2, rx_byte[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            rst <= R_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        rst     <= R_IDLE;
                        rx_vld  <= rx_s2;
                        rx_ferr <= !rx_s2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: rst <= R_IDLE;
            endcase
        end
    end

    ld_st_t      lst;
    logic [7:0]  n_words;
    logic [7:0]  widx;
    logic [1:0]  bidx;
    logic [23:0] wbuf;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lst     <= L_IDLE;
            n_words <= '0;
            widx    <= '0;
            bidx    <= '0;
            wbuf    <= '0;
            WE      <= 1'b0;
            A       <= '0;
            WD      <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            WE   <= 1'b0;
            DONE <= 1'b0;
            case (lst)
                L_IDLE: begin
                    if (rx_ferr) begin
                        ERR <= 1'b1;
                    end else if (rx_vld && rx_byte == 8'h55) begin
                        lst  <= L_COUNT;
                        BUSY <= 1'b1;
                        ERR  <= 1'b0;
                    end
                end
                L_COUNT: begin
                    if (rx_ferr || (rx_vld &&
                        (rx_byte == 8'd0 || rx_byte > N_MAX))) begin
                        ERR  <= 1'b1;
                        BUSY <= 1'b0;
                        lst  <= L_IDLE;
                    end else if (rx_vld) begin
                        n_words <= rx_byte;
                        widx    <= '0;
                        bidx    <= '0;
                        lst     <= L_DATA;
                    end
                end
                L_DATA: begin
                    if (rx_ferr) begin
                        ERR  <= 1'b1;
                        BUSY <= 1'b0;
                        lst  <= L_IDLE;
                    end else if (rx_vld) begin
                        bidx <= bidx + 2'd1;
                        case (bidx)
                            2'd0: wbuf[7:0]   <= rx_byte;
                            2'd1: wbuf[15:8]  <= rx_byte;
                            2'd2: wbuf[23:16] <= rx_byte;
                            default: begin
                                WE  <= 1'b1;
                                A   <= {22'b0, widx, 2'b00};
                                WD  <= {rx_byte, wbuf};
                                lst <= L_WRITE;
                            end
                        endcase
                    end
                end
                L_WRITE: begin
                    widx <= widx + 8'd1;
                    if (rx_ferr) begin
                        ERR  <= 1'b1;
                        BUSY <= 1'b0;
                        lst  <= L_IDLE;
                    end else if (widx + 8'd1 == n_words) begin
                        DONE <= 1'b1;
                        BUSY <= 1'b0;
                        lst  <= L_IDLE;
                    end else begin
                        lst <= L_DATA;
                    end
                end
                default: lst <= L_IDLE;
            endcase
        end
    end

endmodule
